// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches, queues {pc,instr} pairs for decode and
// drops stale responses after a redirect. Optional perf counters: define FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FQ_DEPTH        = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);
  localparam logic [CNT_W-1:0] MAXO_C  = CNT_W'(MAX_OUTSTANDING);
  localparam logic STATE_RUN   = 1'b0;
  localparam logic STATE_FLUSH = 1'b1;

  logic [31:0]      fpc_q, fpc_d;
  logic [31:0]      rpc_q, rpc_d;
  logic [CNT_W-1:0] osc_q, osc_d;
  logic [CNT_W-1:0] dc_q, dc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             state_q, state_d;
  logic [31:0]      fifo_pc_q [FQ_DEPTH];
  logic [31:0]      fifo_pc_d [FQ_DEPTH];
  logic [31:0]      fifo_instr_q [FQ_DEPTH];
  logic [31:0]      fifo_instr_d [FQ_DEPTH];

  logic             req_fire;
  logic             pop;
  logic             push;
  logic [CNT_W:0]   occupancy;

  always_comb begin
    fpc_d        = fpc_q;
    rpc_d        = rpc_q;
    osc_d        = osc_q;
    dc_d         = dc_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    push         = 1'b0;

    // Outstanding requests reserve queue slots so a response can always be accepted.
    occupancy      = {1'b0, osc_q} + {1'b0, count_q};
    imem_req_valid = reset && !redirect_valid && (osc_q < MAXO_C)
                     && (occupancy < {1'b0, DEPTH_C});
    req_fire       = imem_req_valid && imem_req_ready;
    out_valid      = (count_q != '0);
    pop            = out_valid && out_ready;

    if (redirect_valid) begin
      fpc_d    = redirect_pc & ~32'd3;
      rpc_d    = redirect_pc & ~32'd3;
      osc_d    = osc_q - CNT_W'(imem_resp_valid);
      dc_d     = osc_q - CNT_W'(imem_resp_valid);
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (req_fire) begin
        fpc_d = fpc_q + 32'd4;
      end
      osc_d = osc_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
      if (imem_resp_valid) begin
        if (state_q == STATE_FLUSH) begin
          dc_d = dc_q - CNT_W'(1);
        end else begin
          push  = 1'b1;
          rpc_d = rpc_q + 32'd4;
        end
      end
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = rpc_q;
        fifo_instr_d[wr_ptr_q] = imem_resp_data;
        wr_ptr_d               = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    state_d = (dc_d != '0) ? STATE_FLUSH : STATE_RUN;
  end

  assign imem_req_addr = fpc_q;
  assign out_pc        = out_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
  assign out_instr     = out_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q    <= RESET_PC;
      rpc_q    <= RESET_PC;
      osc_q    <= '0;
      dc_q     <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= STATE_RUN;
    end else begin
      fpc_q    <= fpc_d;
      rpc_q    <= rpc_d;
      osc_q    <= osc_d;
      dc_q     <= dc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
    end
  end

  // Queue storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    fifo_pc_q    <= fifo_pc_d;
    fifo_instr_q <= fifo_instr_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_stall_d   = perf_stall_q + 32'(out_ready && !out_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model, output scoreboard, redirect vector table.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct {
    logic [31:0] pre_pc;
    logic [31:0] target;
    bit          stall;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  req_t        pend[$];
  ent_t        sb[$];
  logic [31:0] dlv[$];
  int          dlv_cyc[$];
  logic [31:0] req_addr_log[$];
  int          req_cyc_log[$];
  logic [31:0] exp_fetch;
  bit          mem_stall;
  int          cyc_n;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic fail_now(input string nm, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One clock: sample at +1 after negedge, update the model +1 after posedge.
  task automatic cyc();
    bit          rd, rsp, rf, pp, exp_rv;
    logic [31:0] ra;
    req_t        r;
    ent_t        e;
    #1;
    rd  = redirect_valid;
    rsp = imem_resp_valid;
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    exp_rv = !rd && (pend.size() < MAXO) && (pend.size() + sb.size() < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    rf = imem_req_valid && imem_req_ready;
    ra = imem_req_addr;
    if (rf) check("req_addr", ra, exp_fetch);
    pp = out_valid && out_ready;
    if (pp) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc %h, nothing expected", out_pc);
      end else begin
        check("out_pc", out_pc, sb[0].pc);
        check("out_instr", out_instr, sb[0].instr);
      end
      dlv.push_back(out_pc);
      dlv_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    #1;
    if (pp && sb.size() != 0) void'(sb.pop_front());
    if (rsp && pend.size() != 0) begin
      r = pend.pop_front();
      if (!r.stale && !rd) begin
        e.pc    = r.addr;
        e.instr = instr_of(r.addr);
        sb.push_back(e);
      end
    end
    if (rd) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      sb.delete();
      exp_fetch = redirect_pc & ~32'd3;
    end
    if (rf) begin
      r.addr  = ra;
      r.stale = 1'b0;
      pend.push_back(r);
      req_addr_log.push_back(ra);
      req_cyc_log.push_back(cyc_n);
      exp_fetch += 32'd4;
    end
    cyc_n++;
    imem_resp_valid = !mem_stall && pend.size() != 0;
    imem_resp_data  = imem_resp_valid ? instr_of(pend[0].addr) : 32'h0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    mem_stall       = 1'b0;
    pend.delete();
    sb.delete();
    dlv.delete();
    dlv_cyc.delete();
    req_addr_log.delete();
    req_cyc_log.delete();
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_stall", perf_stall, 32'h0);
`endif
    @(negedge clk);
    reset     = 1'b1;
    exp_fetch = RPC;
    cyc_n     = 0;
  endtask

  task automatic run_until_dlv(input int n, input int budget);
    int k = 0;
    while (dlv.size() < n && k < budget) begin
      cyc();
      k++;
    end
    if (dlv.size() < n) fail_now("dlv_timeout", dlv.size(), n);
  endtask

  // Leave exactly two requests (pre, pre+4) outstanding with the memory stalled.
  task automatic setup_two(input logic [31:0] pre);
    int k = 0;
    mem_stall      = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    while (pend.size() != 0 && k < 10) begin cyc(); k++; end
    if (pend.size() != 0) fail_now("drain_timeout", pend.size(), 0);
    redirect_valid = 1'b1;
    redirect_pc    = pre;
    cyc();
    redirect_valid = 1'b0;
    mem_stall      = 1'b1;
    imem_req_ready = 1'b1;
    k = 0;
    while (pend.size() < 2 && k < 10) begin cyc(); k++; end
    if (pend.size() < 2) fail_now("two_out_timeout", pend.size(), 2);
    else begin
      check("two_out_a", pend[0].addr, pre);
      check("two_out_b", pend[1].addr, pre + 32'd4);
    end
  endtask

  vec_t vt[4];

  initial begin
    int base;
    int k;
    vt[0] = '{pre_pc: 32'h10,   target: 32'h100,       stall: 1'b1, exp0: 32'h100,       exp1: 32'h104};
    vt[1] = '{pre_pc: 32'h0,    target: 32'h203,       stall: 1'b0, exp0: 32'h200,       exp1: 32'h204};
    vt[2] = '{pre_pc: 32'h0,    target: 32'hFFFF_FFFC, stall: 1'b0, exp0: 32'hFFFF_FFFC, exp1: 32'h0};
    vt[3] = '{pre_pc: 32'h7F0,  target: 32'h1002,      stall: 1'b1, exp0: 32'h1000,      exp1: 32'h1004};

    reset          = 1'b0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    cyc_n          = 0;
    do_reset();

    // Back-to-back fetch with a 1-cycle memory and decode always ready.
    repeat (6) cyc();
    check("seq_req_count", req_addr_log.size(), 6);
    check("seq_dlv_count", dlv.size(), 4);
    for (int i = 0; i < 3; i++) begin
      check("seq_req_addr", req_addr_log[i], 32'(4 * i));
      check("seq_req_edge", req_cyc_log[i], i);
      check("seq_dlv_pc", dlv[i], 32'(4 * i));
      check("seq_dlv_edge", dlv_cyc[i], i + 2);
    end

    // Reset with requests in flight, then fill the queue with decode stalled.
    do_reset();
    out_ready = 1'b0;
    repeat (20) cyc();
    check("fill_req_count", req_addr_log.size(), DEPTH);
    check("fill_first_req", req_addr_log[0], RPC);
    check("fill_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    run_until_dlv(4, 20);
    for (int i = 0; i < 4; i++) check("drain_pc", dlv[i], 32'(4 * i));

    // Redirect vectors.
    for (int v = 0; v < 4; v++) begin
      out_ready      = 1'b1;
      imem_req_ready = 1'b1;
      if (vt[v].stall) begin
        setup_two(vt[v].pre_pc);
        redirect_valid = 1'b1;
        redirect_pc    = vt[v].target;
        cyc();
        redirect_valid = 1'b0;
        mem_stall      = 1'b0;
      end else begin
        k = 0;
        while (!(out_valid && imem_resp_valid) && k < 20) begin cyc(); k++; end
        if (!(out_valid && imem_resp_valid)) fail_now("busy_timeout", k, 20);
        base           = dlv.size();
        redirect_valid = 1'b1;
        redirect_pc    = vt[v].target;
        cyc();
        redirect_valid = 1'b0;
        check("pop_on_redirect", dlv.size(), base + 1);
      end
      base = dlv.size();
      run_until_dlv(base + 2, 30);
      check("vec_first_pc", dlv[base], vt[v].exp0);
      check("vec_second_pc", dlv[base + 1], vt[v].exp1);
    end

    // A second redirect during the flush restarts the drop count.
    setup_two(32'h3000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000;
    cyc();
    redirect_pc    = 32'h5000;
    cyc();
    redirect_valid = 1'b0;
    mem_stall      = 1'b0;
    base = dlv.size();
    run_until_dlv(base + 2, 30);
    check("reflush_first_pc", dlv[base], 32'h5000);
    check("reflush_second_pc", dlv[base + 1], 32'h5004);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    repeat (3) cyc();
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;
    repeat (8) cyc();
    k = 0;
    while (dlv.size() < 5 && k < 30) begin
      out_ready = out_valid;
      cyc();
      k++;
    end
    out_ready = 1'b0;
    cyc();
    check("perf_fetched", perf_fetched, 32'd5);
    check("perf_stall", perf_stall, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
